spi_word_rx: RTL and testbench
==============================

// Module: spi_word_rx
// PURPOSE
//  SPI receive end for the debug word links: samples an external sck/cs/mosi triple
//  (cs active-low, MSB first, one 32-bit word per cs-low frame, mosi valid on rising sck).
//  Synchronises the pins into clk, assembles complete words, buffers them in a small FIFO
//  and presents them on a valid/ready stream. Used by the debug host side and SoC loopback benches.
// PARAMETERS
//  WORD_W   32  bits per frame
//  DEPTH    4   FIFO entries (power of two, >=2)
//  SYNC     2   synchroniser flops per input pin (>=2)
// PORTS
//  clk        in   1       system clock; sck high/low phases each >= SYNC+2 clk periods
//  rst_n      in   1       asynchronous active-low reset
//  spi_sck    in   1       serial clock, asynchronous to clk
//  spi_cs     in   1       chip select, active-low, asynchronous
//  spi_mosi   in   1       serial data, asynchronous
//  rx_data    out  WORD_W  head-of-FIFO word
//  rx_valid   out  1       FIFO non-empty
//  rx_ready   in   1       consumer accepts; pop when rx_valid && rx_ready
//  frame_err  out  1       1-cycle pulse: short frame or extra bits in frame
//  overflow   out  1       1-cycle pulse: completed word dropped, FIFO full
// BEHAVIOUR
//  Reset: all sync flops = idle (sck 0, cs 1, mosi 0), FSM IDLE, bit count 0, shift reg 0,
//   FIFO empty; rx_valid=0, rx_data=0, frame_err=0, overflow=0. Reset mid-frame discards it.
//  Edges detected on synchronised signals: sck_rise = s_sck & ~s_sck_d; cs_fall/cs_rise alike.
//  FSM:
//   IDLE  : cs_fall -> SHIFT, count<=0. sck edges ignored while cs high.
//   SHIFT : sck_rise -> shreg<={shreg[WORD_W-2:0], s_mosi}, count++; on the WORD_W-th bit
//           -> push {..., s_mosi} into FIFO (or overflow pulse if full) and go DONE.
//           cs_rise with count<WORD_W -> frame_err pulse, discard, IDLE.
//   DONE  : further sck_rise -> frame_err pulse once per frame, stay DONE; cs_rise -> IDLE.
//  Same-cycle cs_rise and sck_rise: sck_rise processed first (bit counts), then cs_rise.
//  Push latency: word visible on rx_data/rx_valid 1 clk after the synchronised final sck_rise.
//  FIFO: registered pointers, one extra wrap bit; full = ptrs equal except MSB.
//   push and pop same cycle: legal when non-empty, even if full (occupancy unchanged, no overflow).
//   push into empty: rx_valid rises next cycle. rx_data is undefined-stable (last value) when empty.
//   Pop with rx_valid=0 ignored. rx_data/rx_valid must not change while rx_valid && !rx_ready
//   except by reset.
//  Counter width $clog2(WORD_W+1); no wrap, since SHIFT leaves at WORD_W.
//  frame_err and overflow never both asserted in the same cycle from one event.
// STRUCTURE
//  spi_pkg: WORD_W default, SPI_CNT_W, typedef enum {RX_IDLE, RX_SHIFT, RX_DONE} spi_rx_state_t.
//  Sub-module: spi_rx_fifo (sync FIFO, DEPTH x WORD_W, push/pop/full/empty/head).
//  Synchronisers and edge detect inline; shared with no other block.
// TESTING
//  Reset: hold rst_n=0 with random pins -> rx_valid=0, frame_err=0, overflow=0; release, no pushes.
//  Single frame 0xDEADBEEF MSB-first, sck = clk/8 -> one word 0xDEADBEEF, rx_valid within
//   SYNC+2 clk of final rising sck, frame_err never asserted.
//  Back-to-back frames 0x00000001, 0x80000000, 0xFFFFFFFF, rx_ready=1 -> three words in order.
//  Short frame: 17 bits then cs high -> frame_err single pulse, no push; next good frame accepted.
//  Long frame: 40 bits of 0x12345678_AB -> word 0x12345678 pushed, one frame_err pulse.
//  rx_ready=0, DEPTH+1 frames -> first DEPTH words retained, overflow pulse on last; then drain,
//   simultaneous push/pop while full keeps order, no overflow. Assert rst_n mid-frame -> discarded.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word receiver.
package spi_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int SPI_CNT_W  = $clog2(WORD_W_DEF + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_DONE
    } spi_rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO holding completed SPI words; head word is shown combinationally.
module spi_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_pop_en;
    logic w_push_en;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_en  = i_pop & ~o_empty;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign w_push_en = i_push & (~o_full | w_pop_en);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage; cleared on reset so the idle head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/spi_word_rx.sv
// SPI slave receive path: pin synchronisers, frame FSM, word FIFO and valid/ready output.
module spi_word_rx
    import spi_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 4,
    parameter int SYNC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overflow
);

    localparam int CNT_W = (WORD_W == WORD_W_DEF) ? SPI_CNT_W : $clog2(WORD_W + 1);

    logic [SYNC-1:0]   r_sck_sync;
    logic [SYNC-1:0]   r_cs_sync;
    logic [SYNC-1:0]   r_mosi_sync;
    logic              r_sck_d;
    logic              r_cs_d;

    spi_rx_state_t     r_state;
    logic [CNT_W-1:0]  r_count;
    logic [WORD_W-1:0] r_shreg;
    logic              r_err_sent;
    logic              r_frame_err;
    logic              r_overflow;

    logic              w_sck;
    logic              w_cs;
    logic              w_mosi;
    logic              w_sck_rise;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_last_bit;
    logic [WORD_W-1:0] w_next_word;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic [WORD_W-1:0] w_head;

    // Pin synchronisers plus one delay stage for edge detection; reset to idle pin levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC-2:0], spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC-2:0], spi_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC-2:0], spi_mosi};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sck       = r_sck_sync[SYNC-1];
    assign w_cs        = r_cs_sync[SYNC-1];
    assign w_mosi      = r_mosi_sync[SYNC-1];
    assign w_sck_rise  = w_sck & ~r_sck_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_next_word = {r_shreg[WORD_W-2:0], w_mosi};
    assign w_last_bit  = (r_state == RX_SHIFT) && w_sck_rise &&
                         (r_count == CNT_W'(WORD_W - 1));
    assign w_pop       = rx_ready & ~w_fifo_empty;

    // Frame FSM; a coincident sck rise is taken before cs rise, so a word completed
    // on the same cycle as cs rising is still pushed and the FSM lands in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RX_IDLE;
            r_count     <= '0;
            r_shreg     <= '0;
            r_err_sent  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= RX_SHIFT;
                        r_count <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (w_sck_rise) begin
                        r_shreg <= w_next_word;
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (w_last_bit) begin
                        r_overflow <= w_fifo_full & ~w_pop;
                        r_err_sent <= 1'b0;
                        r_state    <= w_cs_rise ? RX_IDLE : RX_DONE;
                    end else if (w_cs_rise) begin
                        r_frame_err <= 1'b1;
                        r_state     <= RX_IDLE;
                    end
                end
                RX_DONE: begin
                    if (w_sck_rise && !r_err_sent) begin
                        r_frame_err <= 1'b1;
                        r_err_sent  <= 1'b1;
                    end
                    if (w_cs_rise) r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    spi_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_last_bit),
        .i_push_data (w_next_word),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign rx_data   = w_head;
    assign rx_valid  = ~w_fifo_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed + randomised bench for spi_word_rx against a frame-level reference model.
`define CHK(TAG, OBS, EXP) \
    begin \
        n_cmp++; \
        assert ((OBS) === (EXP)) else begin \
            n_bad++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_spi_word_rx;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = 4;

    logic          clk;
    logic          rst_n;
    logic          spi_sck;
    logic          spi_cs;
    logic          spi_mosi;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overflow;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [W-1:0]  q[$];
    int            exp_err = 0;
    int            exp_ovf = 0;
    int            err_cycles = 0;
    int            err_rises = 0;
    int            ovf_cycles = 0;
    int            ovf_rises = 0;
    logic          prev_err = 1'b0;
    logic          prev_ovf = 1'b0;
    logic          prev_hold = 1'b0;
    logic [W-1:0]  prev_data = '0;

    spi_word_rx #(
        .WORD_W (W),
        .DEPTH  (DEPTH),
        .SYNC   (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sck   (spi_sck),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream monitor: pops the model queue on handshakes, checks hold stability and pulse bookkeeping.
    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        #2;
        if (rst_n) begin
            if (frame_err) begin
                err_cycles++;
                if (!prev_err) err_rises++;
            end
            if (overflow) begin
                ovf_cycles++;
                if (!prev_ovf) ovf_rises++;
            end
            `CHK("err_ovf_exclusive", frame_err & overflow, 1'b0)
            if (prev_hold) begin
                `CHK("hold_valid", rx_valid, 1'b1)
                `CHK("hold_data", rx_data, prev_data)
            end
            if (rx_valid && rx_ready) begin
                n_cmp++;
                assert (q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL pop_unexpected: observed word %0h expected no word", rx_data);
                end
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    `CHK("pop_data", rx_data, exp_w)
                end
            end
            prev_hold = rx_valid & ~rx_ready;
            prev_data = rx_data;
            prev_err  = frame_err;
            prev_ovf  = overflow;
        end else begin
            prev_hold = 1'b0;
            prev_err  = 1'b0;
            prev_ovf  = 1'b0;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_sck = 1'b0;
        spi_cs  = 1'b0;
        wait_clks(HALF + 2);
    endtask

    task automatic cs_high();
        spi_sck = 1'b0;
        wait_clks(HALF);
        spi_cs = 1'b1;
        wait_clks(2 * HALF);
        spi_mosi = 1'b0;
    endtask

    // One bit: HALF clk low then HALF clk high; caller is at a negedge.
    // The model records the word when the 32nd bit's sck rises.
    task automatic send_bit(input logic b, input bit is_push, input bit pop_here,
                            input bit lat_chk, input logic [W-1:0] word);
        bit seen;
        seen     = 1'b0;
        spi_mosi = b;
        spi_sck  = 1'b0;
        wait_clks(HALF);
        spi_sck = 1'b1;
        if (is_push) begin
            if (q.size() < DEPTH || pop_here) q.push_back(word);
            else exp_ovf++;
        end
        for (int k = 0; k < HALF; k++) begin
            @(negedge clk);
            if (pop_here && k == SYNC - 1) rx_ready = 1'b1;
            if (pop_here && k == SYNC)     rx_ready = 1'b0;
            if (lat_chk && !seen && rx_valid) begin
                seen = 1'b1;
                `CHK("latency_data", rx_data, word)
            end
        end
        if (lat_chk) `CHK("latency_valid", seen, 1'b1)
    endtask

    // Frame of nbits taken MSB-first from the low nbits of data.
    task automatic send_frame(input logic [63:0] data, input int nbits,
                              input bit pop_last, input bit lat_chk);
        logic [W-1:0] word;
        logic [63:0]  shifted;
        word = '0;
        if (nbits >= W) begin
            shifted = data >> (nbits - W);
            word    = shifted[W-1:0];
        end
        cs_low();
        for (int i = 0; i < nbits; i++) begin
            send_bit(data[nbits-1-i], i == W - 1, pop_last && (i == W - 1),
                     lat_chk && (i == W - 1), word);
        end
        cs_high();
        if (nbits != W) exp_err++;
    endtask

    initial begin
        logic [31:0] r0;
        logic [31:0] r1;
        int          nb;

        rst_n    = 1'b0;
        rx_ready = 1'b0;
        spi_sck  = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;

        // Reset held with toggling pins
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r0       = $urandom;
            spi_sck  = r0[0];
            spi_cs   = r0[1];
            spi_mosi = r0[2];
            rx_ready = r0[3];
        end
        `CHK("rst_valid", rx_valid, 1'b0)
        `CHK("rst_err", frame_err, 1'b0)
        `CHK("rst_ovf", overflow, 1'b0)
        `CHK("rst_data", rx_data, 32'h0)
        spi_sck  = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        rx_ready = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(10);
        `CHK("post_rst_valid", rx_valid, 1'b0)

        // Single frame, latency check while held
        send_frame(64'hDEADBEEF, W, 1'b0, 1'b1);
        `CHK("single_valid", rx_valid, 1'b1)
        `CHK("single_data", rx_data, 32'hDEADBEEF)
        `CHK("single_err", err_rises, exp_err)
        rx_ready = 1'b1;
        wait_clks(3);
        `CHK("single_drained", q.size(), 0)
        `CHK("single_empty", rx_valid, 1'b0)

        // Back-to-back frames
        send_frame(64'h00000001, W, 1'b0, 1'b0);
        send_frame(64'h80000000, W, 1'b0, 1'b0);
        send_frame(64'hFFFFFFFF, W, 1'b0, 1'b0);
        wait_clks(3);
        `CHK("b2b_drained", q.size(), 0)
        `CHK("b2b_err", err_rises, exp_err)

        // Short frame then a good one
        r0 = $urandom;
        send_frame({32'h0, r0}, 17, 1'b0, 1'b0);
        `CHK("short_err", err_rises, exp_err)
        `CHK("short_err_width", err_cycles, exp_err)
        `CHK("short_no_push", rx_valid, 1'b0)
        r0 = $urandom;
        send_frame({32'h0, r0}, W, 1'b0, 1'b0);
        wait_clks(3);
        `CHK("after_short_drained", q.size(), 0)

        // Long frame: first 32 bits kept, one error pulse for the extras
        send_frame(64'h0000_0012_3456_78AB, 40, 1'b0, 1'b0);
        wait_clks(3);
        `CHK("long_err", err_rises, exp_err)
        `CHK("long_err_width", err_cycles, exp_err)
        `CHK("long_drained", q.size(), 0)

        // Random lengths and contents
        for (int f = 0; f < 6; f++) begin
            r0 = $urandom;
            r1 = $urandom;
            nb = (f == 0) ? 0 : int'($urandom_range(0, 40));
            send_frame({r1, r0}, nb, 1'b0, 1'b0);
        end
        wait_clks(3);
        `CHK("rand_err", err_rises, exp_err)
        `CHK("rand_drained", q.size(), 0)

        // Overflow: DEPTH+1 frames with consumer stalled
        rx_ready = 1'b0;
        for (int f = 0; f < DEPTH + 1; f++) begin
            r0 = $urandom;
            send_frame({32'h0, r0}, W, 1'b0, 1'b0);
        end
        `CHK("ovf_pulse", ovf_rises, exp_ovf)
        `CHK("ovf_width", ovf_cycles, exp_ovf)
        `CHK("ovf_kept", q.size(), DEPTH)
        `CHK("ovf_head", rx_data, q[0])
        // Push and pop in the same cycle while full
        r0 = $urandom;
        send_frame({32'h0, r0}, W, 1'b1, 1'b0);
        `CHK("pushpop_no_ovf", ovf_rises, exp_ovf)
        `CHK("pushpop_occupancy", q.size(), DEPTH)
        `CHK("pushpop_head", rx_data, q[0])
        rx_ready = 1'b1;
        wait_clks(DEPTH + 4);
        `CHK("ovf_drained", q.size(), 0)
        `CHK("ovf_empty", rx_valid, 1'b0)

        // Reset in mid-frame discards the partial word
        cs_low();
        for (int i = 0; i < 10; i++) begin
            r0 = $urandom;
            send_bit(r0[0], 1'b0, 1'b0, 1'b0, '0);
        end
        rst_n = 1'b0;
        wait_clks(2);
        `CHK("midrst_valid", rx_valid, 1'b0)
        `CHK("midrst_err", frame_err, 1'b0)
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(5);
        r0 = $urandom;
        send_frame({32'h0, r0}, W, 1'b0, 1'b0);
        wait_clks(3);
        `CHK("midrst_next_drained", q.size(), 0)
        `CHK("midrst_empty", rx_valid, 1'b0)

        // Totals
        `CHK("total_err_pulses", err_rises, exp_err)
        `CHK("total_err_cycles", err_cycles, exp_err)
        `CHK("total_ovf_pulses", ovf_rises, exp_ovf)
        `CHK("total_ovf_cycles", ovf_cycles, exp_ovf)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`undef CHK
